// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with flush drain and registered broadcast
package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  rd_paddr;
    logic [31:0] rd_data;
    logic [4:0]  rob_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_valid;
    logic        br_result;
  } cdb_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_FU = 4,
  localparam int IW = $clog2(N_FU)
) (
  input  logic              clk,
  input  logic              rst,
  input  cdb_t [N_FU-1:0]   fu_cdb,
  input  logic              flush,
  output logic [N_FU-1:0]   fu_taken,
  output cdb_t              cdb_out,
  output logic [IW-1:0]     grant_idx,
  output logic [31:0]       cdb_count
);

  logic [N_FU-1:0] req;
  logic            any_req;
  logic [IW-1:0]   win;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  cdb_t            cdb_q, cdb_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [31:0]     cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < N_FU; i++) begin
      req[i] = fu_cdb[i].valid;
    end
  end

  assign any_req = |req;

  // Two descending passes: lowest requester overall, then overridden by the
  // lowest requester at or above rr_ptr, giving a wrapped search from rr_ptr.
  always_comb begin
    win = '0;
    for (int i = N_FU - 1; i >= 0; i--) begin
      if (req[i]) win = IW'(i);
    end
    for (int i = N_FU - 1; i >= 0; i--) begin
      if (req[i] && (IW'(i) >= rr_ptr_q)) win = IW'(i);
    end
  end

  always_comb begin
    fu_taken = '0;
    if (rst) begin
      fu_taken = '0;
    end else if (flush) begin
      fu_taken = req;
    end else begin
      fu_taken[win] = any_req;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    cdb_d    = '0;
    gidx_d   = gidx_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (any_req) begin
      cdb_d       = fu_cdb[win];
      cdb_d.valid = 1'b1;
      gidx_d      = win;
      cnt_d       = cnt_q + 32'd1;
      rr_ptr_d    = (win == IW'(N_FU - 1)) ? '0 : win + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cdb_out   = cdb_q;
  assign grant_idx = gidx_q;
  assign cdb_count = cnt_q;

endmodule
